// File: rtl/stream_upsizer_if.sv
// Narrow-in / wide-out stream bundle for the upsizer: 8-bit style beats in,
// RATIO-lane packed words with keep/last out.
interface stream_upsizer_if #(
    parameter int IN_W  = 8,
    parameter int RATIO = 4
);
    localparam int OUT_W = IN_W * RATIO;

    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic [RATIO-1:0] out_keep;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_keep, out_last, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_keep, out_last, out_valid
    );
endinterface

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow beats little-endian into one registered wide word; in_last
// closes a short word early and the keep mask marks the lanes actually filled.
module stream_upsizer #(
    parameter int IN_W  = 8,
    parameter int RATIO = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    stream_upsizer_if.slave bus
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int CNT_W = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0]             cnt_r;
    logic [RATIO-2:0][IN_W-1:0]   acc_r;
    logic [OUT_W-1:0]             out_data_r;
    logic [RATIO-1:0]             out_keep_r;
    logic                         out_last_r;
    logic                         out_valid_r;

    logic                         slot_free_s;
    logic                         completing_s;
    logic                         in_ready_s;
    logic                         accept_s;
    logic                         load_s;
    logic [OUT_W-1:0]             acc_ext_s;
    logic [OUT_W-1:0]             word_s;
    logic [RATIO-1:0]             keep_s;

    // Handshake decode: a stalled output only blocks the beat that would complete a word.
    always_comb begin
        slot_free_s  = !out_valid_r || bus.out_ready;
        completing_s = (cnt_r == LAST_LANE) || bus.in_last;
        in_ready_s   = rst_n && (slot_free_s || !completing_s);
        accept_s     = bus.in_valid && in_ready_s;
        load_s       = accept_s && completing_s;
    end

    // Assemble the candidate word: buffered lanes below cnt, the live beat at cnt, zeros above.
    always_comb begin
        acc_ext_s = {{IN_W{1'b0}}, acc_r};
        word_s    = {OUT_W{1'b0}};
        keep_s    = {RATIO{1'b0}};
        for (int k = 0; k < RATIO; k++) begin
            if (CNT_W'(k) < cnt_r) begin
                word_s[k*IN_W +: IN_W] = acc_ext_s[k*IN_W +: IN_W];
                keep_s[k]              = 1'b1;
            end else if (CNT_W'(k) == cnt_r) begin
                word_s[k*IN_W +: IN_W] = bus.in_data;
                keep_s[k]              = 1'b1;
            end else begin
                word_s[k*IN_W +: IN_W] = {IN_W{1'b0}};
                keep_s[k]              = 1'b0;
            end
        end
    end

    // Lane counter and accumulator for the partial word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
            acc_r <= {((RATIO-1)*IN_W){1'b0}};
        end else if (accept_s) begin
            if (completing_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
                for (int k = 0; k < RATIO - 1; k++) begin
                    if (cnt_r == CNT_W'(k)) begin
                        acc_r[k] <= bus.in_data;
                    end
                end
            end
        end
    end

    // Output word register: reload wins over drain so back-to-back words have no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_r  <= {OUT_W{1'b0}};
            out_keep_r  <= {RATIO{1'b0}};
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_data_r  <= word_s;
            out_keep_r  <= keep_s;
            out_last_r  <= bus.in_last;
            out_valid_r <= 1'b1;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_data  = out_data_r;
    assign bus.out_keep  = out_keep_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_valid = out_valid_r;
endmodule
